// File: rtl/uart_tx_fifo_if.sv
// Push-side handshake bundle for uart_tx_fifo: the sender drives the word and
// valid, the transmitter answers with ready (FIFO not full).
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_din_i;
   logic                 tx_valid_i;
   logic                 tx_ready_o;

   modport master (output tx_din_i, output tx_valid_i, input tx_ready_o);
   modport slave  (input tx_din_i, input tx_valid_i, output tx_ready_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO and back-to-back framing.
// Define UART_TX_PARITY_EN to build the optional even/odd parity bit.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                               clk_i,
   input  logic                               rstn_i,
   uart_tx_fifo_if.slave                      push,
   input  logic [1:0]                         parity_mode_i,
   output logic                               tx_o,
   output logic                               tx_active_o,
   output logic                               tx_done_tick_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST  = (STOP_BITS == 2);
   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

   state_e               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic                 pop, push_fire, bit_end, fifo_nonempty;
`ifdef UART_TX_PARITY_EN
   logic                 par_en_q, par_en_d, par_bit_q, par_bit_d;
`else
   logic                 unused_parity;
   assign unused_parity = ^parity_mode_i;
`endif

   assign push.tx_ready_o = (count_q != DEPTH_C);
   assign push_fire       = push.tx_valid_i && push.tx_ready_o;
   assign fifo_nonempty   = (count_q != '0);
   assign bit_end         = (timer_q == TIMER_LAST);

   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      state_d  = state_q;
      timer_d  = timer_q + TW'(1);
      bit_d    = bit_q;
      stop_d   = stop_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
`endif
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (fifo_nonempty) begin
               pop     = 1'b1;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: if (bit_end) begin
            state_d = DATA;
            timer_d = '0;
            tx_d    = shift_q[0];
         end
         DATA: if (bit_end) begin
            timer_d = '0;
            if (bit_q == BIT_LAST) begin
               bit_d   = '0;
               state_d = STOP;
               tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
               if (par_en_q) begin
                  state_d = PARITY;
                  tx_d    = par_bit_q;
               end
`endif
            end else begin
               bit_d   = bit_q + BW'(1);
               shift_d = shift_q >> 1;
               tx_d    = shift_q[1];
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) begin
            state_d = STOP;
            timer_d = '0;
            tx_d    = 1'b1;
         end
`endif
         STOP: if (bit_end) begin
            timer_d = '0;
            if (stop_q == STOP_LAST) begin
               stop_d = 1'b0;
               // Chain straight into the next start bit: no idle high time.
               if (fifo_nonempty) begin
                  pop     = 1'b1;
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               stop_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
            tx_d    = 1'b1;
         end
      endcase

      if (pop) begin
         shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
         // Mode is sampled only here, so mid-frame changes wait for the next word.
         par_en_d  = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
         par_bit_d = (^mem_q[rd_ptr_q]) ^ parity_mode_i[1];
`endif
      end

      active_d = (state_d != IDLE);
      done_d   = (state_d == STOP) && (stop_d == STOP_LAST) && (timer_d == TIMER_LAST);
   end

   always_comb begin
      wr_ptr_d = push_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push_fire, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         active_q <= active_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
`endif
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define validity.
   always_ff @(posedge clk_i) begin
      if (push_fire) mem_q[wr_ptr_q] <= push.tx_din_i;
   end

   assign tx_o           = tx_q;
   assign tx_active_o    = active_q;
   assign tx_done_tick_o = done_q;
   assign fifo_count_o   = count_q;
endmodule
